// File: rtl/fp_wire_pkg.sv
// Shared types and constants for the fp_unit result checker.
// Holds the queued expected-vector record, the captured-error record and the canonical NaNs.
package fp_wire;

  localparam logic [31:0] NAN_S = 32'h7FC00000;
  localparam logic [63:0] NAN_D = 64'h7FF8000000000000;

  localparam logic [1:0] FMT_S = 2'd0;
  localparam logic [1:0] FMT_D = 2'd1;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic [1:0]  fmt;
    logic        nanchk;
  } fp_check_exp_type;

  typedef struct packed {
    logic        err;
    logic        underflow;
    logic [63:0] err_exp_result;
    logic [63:0] err_calc_result;
    logic [4:0]  err_exp_flags;
    logic [4:0]  err_calc_flags;
  } fp_check_out_type;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FAIL = 1'b1
  } fp_check_state_type;

endpackage

// File: rtl/fp_check_fifo.sv
// Expected-vector FIFO for fp_unit_check; pointers carry an extra wrap bit so
// full and empty are told apart, and both flags are registered decodes.
module fp_check_fifo
  import fp_wire::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fp_check_exp_type push_data,
  input  logic             pop,
  output fp_check_exp_type head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fp_check_exp_type mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_nxt;
  logic [AW:0] rd_nxt;

  always_comb begin
    wr_nxt = wr_ptr + PW'(push);
    rd_nxt = rd_ptr + PW'(pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  // Storage is data only; emptiness is defined purely by the pointers.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fp_unit_check.sv
// Result checker behind fp_unit: queues expected vectors, compares each delivered
// result with canonical-NaN masking, counts pass/fail and latches the first mismatch.
module fp_unit_check
  import fp_wire::*;
#(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 32,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             reset,
  input  logic             clock,
  input  logic             clear,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [63:0]      exp_result,
  input  logic [4:0]       exp_flags,
  input  logic [1:0]       exp_fmt,
  input  logic             exp_nanchk,
  input  logic             res_valid,
  input  logic [63:0]      res_result,
  input  logic [4:0]       res_flags,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic             underflow,
  output logic [CNT_W-1:0] err_index,
  output logic [63:0]      err_exp_result,
  output logic [63:0]      err_calc_result,
  output logic [4:0]       err_exp_flags,
  output logic [4:0]       err_calc_flags,
  output logic             empty
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic is_mismatch(input fp_check_exp_type e,
                                       input logic [63:0] r,
                                       input logic [4:0] f);
    logic res_diff;
    if (e.fmt == FMT_D) begin
      if (e.nanchk && (r == NAN_D)) res_diff = (e.result[62:51] != r[62:51]);
      else                          res_diff = (e.result != r);
    end else begin
      if (e.nanchk && (r[31:0] == NAN_S)) res_diff = (e.result[30:22] != r[30:22]);
      else                                res_diff = (e.result[31:0] != r[31:0]);
    end
    return res_diff || (e.flags != f);
  endfunction

  fp_check_exp_type   push_data;
  fp_check_exp_type   head;
  logic               full;
  logic               push;
  logic               pop;

  logic               vld_p0;
  logic               uflow_p0;
  fp_check_exp_type   exp_p0;
  logic [63:0]        res_result_p0;
  logic [4:0]         res_flags_p0;
  logic               mismatch_p0;

  fp_check_state_type state_p1;
  fp_check_out_type   out_p1;
  logic [CNT_W-1:0]   pass_cnt_p1;
  logic [CNT_W-1:0]   fail_cnt_p1;
  logic [CNT_W-1:0]   err_index_p1;

  assign push_data = '{result: exp_result, flags: exp_flags, fmt: exp_fmt, nanchk: exp_nanchk};
  assign push      = exp_valid && !full;
  assign pop       = res_valid && !empty;

  fp_check_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  // Stage p0: capture the popped head alongside the delivered result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0   <= 1'b0;
      uflow_p0 <= 1'b0;
    end else if (clear) begin
      vld_p0   <= 1'b0;
      uflow_p0 <= 1'b0;
    end else begin
      vld_p0   <= res_valid;
      uflow_p0 <= empty;
    end
  end

  always_ff @(posedge clock) begin
    exp_p0        <= head;
    res_result_p0 <= res_result;
    res_flags_p0  <= res_flags;
  end

  assign mismatch_p0 = is_mismatch(exp_p0, res_result_p0, res_flags_p0);

  // Stage p1: verdict FSM, saturating counters and first-error capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p1     <= ST_RUN;
      out_p1       <= '0;
      pass_cnt_p1  <= '0;
      fail_cnt_p1  <= '0;
      err_index_p1 <= '0;
    end else if (clear) begin
      state_p1     <= ST_RUN;
      out_p1       <= '0;
      pass_cnt_p1  <= '0;
      fail_cnt_p1  <= '0;
      err_index_p1 <= '0;
    end else if (vld_p0) begin
      if (uflow_p0) begin
        out_p1.err       <= 1'b1;
        out_p1.underflow <= 1'b1;
        state_p1         <= ST_FAIL;
      end else if ((state_p1 == ST_RUN) || (STOP_ON_FAIL == 0)) begin
        if (mismatch_p0) begin
          fail_cnt_p1 <= sat_inc(fail_cnt_p1);
          if (state_p1 == ST_RUN) begin
            state_p1               <= ST_FAIL;
            out_p1.err             <= 1'b1;
            out_p1.err_exp_result  <= exp_p0.result;
            out_p1.err_calc_result <= res_result_p0;
            out_p1.err_exp_flags   <= exp_p0.flags;
            out_p1.err_calc_flags  <= res_flags_p0;
            err_index_p1           <= pass_cnt_p1 + fail_cnt_p1;
          end
        end else begin
          pass_cnt_p1 <= sat_inc(pass_cnt_p1);
        end
      end
    end
  end

  assign exp_ready       = !full;
  assign pass_cnt        = pass_cnt_p1;
  assign fail_cnt        = fail_cnt_p1;
  assign err_index       = err_index_p1;
  assign err             = out_p1.err;
  assign underflow       = out_p1.underflow;
  assign err_exp_result  = out_p1.err_exp_result;
  assign err_calc_result = out_p1.err_calc_result;
  assign err_exp_flags   = out_p1.err_exp_flags;
  assign err_calc_flags  = out_p1.err_calc_flags;

endmodule

// File: tb/tb_fp_unit_check.sv
// Bench for fp_unit_check: directed vector table, hand-written corner sequences,
// and a randomized stream checked against a queue-based reference model.
module tb_fp_unit_check;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             reset;
  logic             clock;
  logic             clear;
  logic             exp_valid;
  logic             exp_ready;
  logic [63:0]      exp_result;
  logic [4:0]       exp_flags;
  logic [1:0]       exp_fmt;
  logic             exp_nanchk;
  logic             res_valid;
  logic [63:0]      res_result;
  logic [4:0]       res_flags;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             err;
  logic             underflow;
  logic [CNT_W-1:0] err_index;
  logic [63:0]      err_exp_result;
  logic [63:0]      err_calc_result;
  logic [4:0]       err_exp_flags;
  logic [4:0]       err_calc_flags;
  logic             empty;

  fp_unit_check #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STOP_ON_FAIL(1)) dut (
    .reset           (reset),
    .clock           (clock),
    .clear           (clear),
    .exp_valid       (exp_valid),
    .exp_ready       (exp_ready),
    .exp_result      (exp_result),
    .exp_flags       (exp_flags),
    .exp_fmt         (exp_fmt),
    .exp_nanchk      (exp_nanchk),
    .res_valid       (res_valid),
    .res_result      (res_result),
    .res_flags       (res_flags),
    .pass_cnt        (pass_cnt),
    .fail_cnt        (fail_cnt),
    .err             (err),
    .underflow       (underflow),
    .err_index       (err_index),
    .err_exp_result  (err_exp_result),
    .err_calc_result (err_calc_result),
    .err_exp_flags   (err_exp_flags),
    .err_calc_flags  (err_calc_flags),
    .empty           (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    exp_valid = 1'b0;
    res_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drive_exp(input logic [63:0] r, input logic [4:0] f, input logic [1:0] fm, input logic n);
    exp_valid  = 1'b1;
    exp_result = r;
    exp_flags  = f;
    exp_fmt    = fm;
    exp_nanchk = n;
  endtask

  task automatic drive_res(input logic [63:0] r, input logic [4:0] f);
    res_valid  = 1'b1;
    res_result = r;
    res_flags  = f;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".exp_ready"}, exp_ready, 1);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".pass_cnt"}, pass_cnt, 0);
    chk({tag, ".fail_cnt"}, fail_cnt, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".underflow"}, underflow, 0);
    chk({tag, ".err_index"}, err_index, 0);
    chk({tag, ".err_exp_result"}, err_exp_result, 0);
    chk({tag, ".err_calc_result"}, err_calc_result, 0);
    chk({tag, ".err_exp_flags"}, err_exp_flags, 0);
    chk({tag, ".err_calc_flags"}, err_calc_flags, 0);
  endtask

  // Reference: a field participates in the compare when its mask bit is set.
  typedef struct {
    logic [63:0] res;
    logic [4:0]  flg;
    logic [1:0]  fmt;
    logic        nan;
  } exp_t;

  function automatic bit ref_match(input exp_t e, input logic [63:0] r, input logic [4:0] f);
    logic [63:0] mask;
    if (e.fmt == 2'd1) mask = (e.nan && r == 64'h7FF8000000000000) ? 64'h7FF8000000000000 : 64'hFFFFFFFFFFFFFFFF;
    else               mask = (e.nan && r[31:0] == 32'h7FC00000) ? 64'h000000007FC00000 : 64'h00000000FFFFFFFF;
    return (((e.res ^ r) & mask) == 64'd0) && (e.flg == f);
  endfunction

  typedef struct {
    logic [63:0] e_res;
    logic [4:0]  e_flg;
    logic [1:0]  fmt;
    logic        nan;
    logic [63:0] r_res;
    logic [4:0]  r_flg;
    logic        pass;
  } vec_t;

  vec_t tab [13];

  exp_t        q [$];
  int unsigned m_pass, m_fail, m_idx;
  bit          m_err, m_uf, m_stop;
  logic [63:0] m_er, m_cr;
  logic [4:0]  m_ef, m_cf;

  task automatic model_clear();
    q.delete();
    m_pass = 0; m_fail = 0; m_idx = 0;
    m_err = 0; m_uf = 0; m_stop = 0;
    m_er = '0; m_cr = '0; m_ef = '0; m_cf = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = '{64'h3F800000, 5'h00, 2'd0, 1'b0, 64'h3F800000, 5'h00, 1'b1};
    tab[1]  = '{64'h3F800000, 5'h00, 2'd0, 1'b0, 64'hFFFFFFFF3F800000, 5'h00, 1'b1};
    tab[2]  = '{64'h7FC00001, 5'h00, 2'd0, 1'b1, 64'h7FC00000, 5'h00, 1'b1};
    tab[3]  = '{64'h7FC00001, 5'h00, 2'd0, 1'b0, 64'h7FC00000, 5'h00, 1'b0};
    tab[4]  = '{64'h7F800001, 5'h10, 2'd0, 1'b1, 64'h7FC00000, 5'h10, 1'b0};
    tab[5]  = '{64'h7FE00000, 5'h10, 2'd0, 1'b1, 64'h7FC00000, 5'h10, 1'b1};
    tab[6]  = '{64'h7FC00001, 5'h00, 2'd0, 1'b1, 64'h7FC00002, 5'h00, 1'b0};
    tab[7]  = '{64'h3FF0000000000000, 5'h01, 2'd1, 1'b0, 64'h3FF0000000000000, 5'h00, 1'b0};
    tab[8]  = '{64'h7FF8000000000001, 5'h00, 2'd1, 1'b1, 64'h7FF8000000000000, 5'h00, 1'b1};
    tab[9]  = '{64'h7FF0000000000001, 5'h00, 2'd1, 1'b1, 64'h7FF8000000000000, 5'h00, 1'b0};
    tab[10] = '{64'h3FF0000000000000, 5'h00, 2'd1, 1'b0, 64'h3FF0000000000001, 5'h00, 1'b0};
    tab[11] = '{64'hC00921FB54442D18, 5'h04, 2'd1, 1'b1, 64'hC00921FB54442D18, 5'h04, 1'b1};
    tab[12] = '{64'h40490FDB, 5'h02, 2'd0, 1'b1, 64'h40490FDB, 5'h03, 1'b0};

    reset = 1'b0; idle();
    exp_result = '0; exp_flags = '0; exp_fmt = '0; exp_nanchk = 1'b0;
    res_result = '0; res_flags = '0;
    tick(); tick();
    chk_reset_state("in_reset");
    reset = 1'b1;
    tick();
    chk_reset_state("after_reset");

    // Directed single-vector table.
    for (int i = 0; i < 13; i++) begin
      do_clear();
      drive_exp(tab[i].e_res, tab[i].e_flg, tab[i].fmt, tab[i].nan);
      tick();
      exp_valid = 1'b0;
      drive_res(tab[i].r_res, tab[i].r_flg);
      tick();
      res_valid = 1'b0;
      chk($sformatf("tab%0d.latency", i), pass_cnt + fail_cnt, 0);
      tick();
      chk($sformatf("tab%0d.pass_cnt", i), pass_cnt, tab[i].pass ? 1 : 0);
      chk($sformatf("tab%0d.fail_cnt", i), fail_cnt, tab[i].pass ? 0 : 1);
      chk($sformatf("tab%0d.err", i), err, tab[i].pass ? 0 : 1);
      chk($sformatf("tab%0d.empty", i), empty, 1);
      if (!tab[i].pass) begin
        chk($sformatf("tab%0d.err_index", i), err_index, 0);
        chk($sformatf("tab%0d.err_exp_result", i), err_exp_result, tab[i].e_res);
        chk($sformatf("tab%0d.err_calc_result", i), err_calc_result, tab[i].r_res);
        chk($sformatf("tab%0d.err_exp_flags", i), err_exp_flags, tab[i].e_flg);
        chk($sformatf("tab%0d.err_calc_flags", i), err_calc_flags, tab[i].r_flg);
      end
    end

    // Second mismatch leaves capture and counters frozen.
    do_clear();
    drive_exp(64'h3FF0000000000000, 5'h01, 2'd1, 1'b0); tick();
    drive_exp(64'h4000000000000000, 5'h00, 2'd1, 1'b0); tick();
    exp_valid = 1'b0;
    drive_res(64'h3FF0000000000000, 5'h00); tick();
    drive_res(64'h4000000000000001, 5'h00); tick();
    res_valid = 1'b0;
    tick(); tick();
    chk("second.fail_cnt", fail_cnt, 1);
    chk("second.pass_cnt", pass_cnt, 0);
    chk("second.err_index", err_index, 0);
    chk("second.err_exp_result", err_exp_result, 64'h3FF0000000000000);
    chk("second.err_calc_result", err_calc_result, 64'h3FF0000000000000);
    chk("second.err_exp_flags", err_exp_flags, 5'h01);
    chk("second.err_calc_flags", err_calc_flags, 5'h00);

    // err_index after some passes.
    do_clear();
    drive_exp(64'h11, 5'h0, 2'd1, 1'b0); tick();
    drive_exp(64'h22, 5'h0, 2'd1, 1'b0); tick();
    drive_exp(64'h33, 5'h0, 2'd1, 1'b0); tick();
    exp_valid = 1'b0;
    drive_res(64'h11, 5'h0); tick();
    drive_res(64'h22, 5'h0); tick();
    drive_res(64'h34, 5'h0); tick();
    res_valid = 1'b0;
    tick();
    chk("index.pass_cnt", pass_cnt, 2);
    chk("index.err_index", err_index, 2);

    // Full FIFO, ignored 9th push, then pop+push at constant occupancy.
    do_clear();
    for (int k = 0; k < DEPTH; k++) begin
      drive_exp(64'h100 + 64'(k), 5'h0, 2'd1, 1'b0);
      tick();
    end
    chk("full.exp_ready", exp_ready, 0);
    drive_exp(64'h108, 5'h0, 2'd1, 1'b0); tick();
    exp_valid = 1'b0;
    chk("full9.exp_ready", exp_ready, 0);
    drive_res(64'h100, 5'h0); tick();
    res_valid = 1'b0;
    chk("pop1.exp_ready", exp_ready, 1);
    drive_res(64'h101, 5'h0);
    drive_exp(64'h109, 5'h0, 2'd1, 1'b0); tick();
    res_valid = 1'b0; exp_valid = 1'b0;
    chk("popush.exp_ready", exp_ready, 1);
    chk("popush.empty", empty, 0);
    for (int j = 0; j < 7; j++) begin
      drive_res((j < 6) ? 64'h102 + 64'(j) : 64'h109, 5'h0);
      tick();
      if (j == 5) chk("drain6.empty", empty, 0);
    end
    res_valid = 1'b0;
    chk("drain.empty", empty, 1);
    tick();
    chk("drain.pass_cnt", pass_cnt, 9);
    chk("drain.err", err, 0);

    // Underflow with a simultaneous push.
    do_clear();
    drive_res(64'h3F800000, 5'h0);
    drive_exp(64'h3F800000, 5'h0, 2'd0, 1'b0);
    tick();
    res_valid = 1'b0; exp_valid = 1'b0;
    tick();
    chk("uf.underflow", underflow, 1);
    chk("uf.err", err, 1);
    chk("uf.pass_cnt", pass_cnt, 0);
    chk("uf.fail_cnt", fail_cnt, 0);
    chk("uf.empty", empty, 0);
    chk("uf.err_exp_result", err_exp_result, 0);
    drive_res(64'h3F800000, 5'h0); tick();
    res_valid = 1'b0; tick();
    chk("uf_frozen.pass_cnt", pass_cnt, 0);
    chk("uf_frozen.empty", empty, 1);

    // Clear with 3 queued entries and err set; a push in the clear cycle is dropped.
    do_clear();
    drive_res(64'h0, 5'h0);
    drive_exp(64'h1, 5'h0, 2'd1, 1'b0); tick();
    res_valid = 1'b0;
    drive_exp(64'h2, 5'h0, 2'd1, 1'b0); tick();
    drive_exp(64'h3, 5'h0, 2'd1, 1'b0); tick();
    exp_valid = 1'b0;
    chk("preclr.err", err, 1);
    drive_exp(64'h4, 5'h0, 2'd1, 1'b0);
    do_clear();
    exp_valid = 1'b0;
    chk_reset_state("clear");

    // Asynchronous reset mid-stream.
    drive_exp(64'h5, 5'h0, 2'd1, 1'b0); tick();
    drive_exp(64'h6, 5'h0, 2'd1, 1'b0); drive_res(64'h5, 5'h0); tick();
    drive_res(64'h7, 5'h0); exp_valid = 1'b0; tick();
    res_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_state("async_reset");
    @(posedge clock); #1;
    reset = 1'b1;
    drive_res(64'h6, 5'h0); tick();
    res_valid = 1'b0; tick();
    chk("post_reset.underflow", underflow, 1);

    // Randomized stream against the queue model.
    for (int round = 0; round < 4; round++) begin
      int unsigned p_pass, p_fail;
      bit          p_err, p_uf;
      do_clear();
      model_clear();
      p_pass = 0; p_fail = 0; p_err = 0; p_uf = 0;
      for (int c = 0; c < 150; c++) begin
        exp_t        ne;
        exp_t        he;
        logic [63:0] rr;
        logic [4:0]  rf;
        int          old_size;
        ne.fmt = 2'($urandom_range(0, 1));
        ne.nan = 1'($urandom_range(0, 1));
        ne.flg = 5'($urandom_range(0, 31));
        ne.res = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) ne.res = (ne.fmt == 2'd1) ? 64'h7FF8000000000000 ^ 64'($urandom_range(0, 1)) : 64'h7FC00000 ^ 64'($urandom_range(0, 1));
        exp_valid  = ($urandom_range(0, 3) != 0);
        exp_result = ne.res; exp_flags = ne.flg; exp_fmt = ne.fmt; exp_nanchk = ne.nan;
        if (q.size() > 0) begin
          he = q[0];
          res_valid = ($urandom_range(0, 2) != 0);
          rr = he.res; rf = he.flg;
          if (he.fmt == 2'd0) rr[63:32] = $urandom;
          if ($urandom_range(0, 3) == 0) rr = (he.fmt == 2'd1) ? 64'h7FF8000000000000 : {$urandom, 32'h7FC00000};
          if ($urandom_range(0, 60) == 0) rr[$urandom_range(0, 63)] ^= 1'b1;
          if ($urandom_range(0, 60) == 0) rf ^= 5'h04;
        end else begin
          res_valid = ($urandom_range(0, 40) == 0);
          rr = {$urandom, $urandom}; rf = 5'($urandom_range(0, 31));
        end
        res_result = rr; res_flags = rf;
        tick();
        chk("rnd.pass_cnt", pass_cnt, p_pass);
        chk("rnd.fail_cnt", fail_cnt, p_fail);
        chk("rnd.err", err, p_err);
        chk("rnd.underflow", underflow, p_uf);
        old_size = q.size();
        if (res_valid) begin
          if (old_size == 0) begin
            m_err = 1; m_uf = 1; m_stop = 1;
          end else begin
            he = q.pop_front();
            if (!m_stop) begin
              if (ref_match(he, rr, rf)) m_pass++;
              else begin
                m_idx = m_pass + m_fail;
                m_fail++; m_err = 1; m_stop = 1;
                m_er = he.res; m_cr = rr; m_ef = he.flg; m_cf = rf;
              end
            end
          end
        end
        if (exp_valid && old_size < DEPTH) q.push_back(ne);
        chk("rnd.empty", empty, (q.size() == 0) ? 1 : 0);
        chk("rnd.exp_ready", exp_ready, (q.size() < DEPTH) ? 1 : 0);
        p_pass = m_pass; p_fail = m_fail; p_err = m_err; p_uf = m_uf;
      end
      idle();
      tick();
      chk("rnd_end.pass_cnt", pass_cnt, m_pass);
      chk("rnd_end.fail_cnt", fail_cnt, m_fail);
      chk("rnd_end.err", err, m_err);
      chk("rnd_end.underflow", underflow, m_uf);
      chk("rnd_end.err_index", err_index, m_idx);
      chk("rnd_end.err_exp_result", err_exp_result, m_er);
      chk("rnd_end.err_calc_result", err_calc_result, m_cr);
      chk("rnd_end.err_exp_flags", err_exp_flags, m_ef);
      chk("rnd_end.err_calc_flags", err_calc_flags, m_cf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
